// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// The master side is the controller; the slave side is the instruction register / datapath.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [3:0] alu_control;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_control, illegal_op, state
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_control, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle CPU: only the state is registered, controls decode from state.
// Optional macro MC_IMM_ALU_EN adds addi/slti through the I_EXEC/I_WB states.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t     state_q, state_d;
  logic [3:0] alu_r;
  logic       funct_ok;

  always_comb begin
    funct_ok = 1'b1;
    case (bus.funct)
      6'b100000: alu_r = ALU_ADD;
      6'b100010: alu_r = ALU_SUB;
      6'b100100: alu_r = ALU_AND;
      6'b100101: alu_r = ALU_OR;
      6'b101010: alu_r = ALU_SLT;
      6'b100111: alu_r = ALU_NOR;
      default: begin
        alu_r    = ALU_ADD;
        funct_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_IMM_ALU_EN
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: state_d = S_MEM_WB;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // DECODE falls back to FETCH for exactly the opcodes it does not route elsewhere.
  logic decode_illegal;
  assign decode_illegal = (state_q == S_DECODE) && (state_d == S_FETCH);

  logic       pc_write_w, i_or_d_w, mem_read_w, mem_write_w, ir_write_w;
  logic       reg_write_w, reg_dst_w, mem_to_reg_w, alu_src_a_w, illegal_w;
  logic [1:0] alu_src_b_w, pc_source_w;
  logic [3:0] alu_control_w;

  always_comb begin
    pc_write_w    = 1'b0;
    i_or_d_w      = 1'b0;
    mem_read_w    = 1'b0;
    mem_write_w   = 1'b0;
    ir_write_w    = 1'b0;
    reg_write_w   = 1'b0;
    reg_dst_w     = 1'b0;
    mem_to_reg_w  = 1'b0;
    alu_src_a_w   = 1'b0;
    alu_src_b_w   = 2'b00;
    pc_source_w   = 2'b00;
    alu_control_w = ALU_ADD;
    illegal_w     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_w  = 1'b1;
        ir_write_w  = 1'b1;
        pc_write_w  = 1'b1;
        alu_src_b_w = 2'b01;
      end
      S_DECODE: begin
        alu_src_b_w = 2'b11;
        illegal_w   = decode_illegal;
      end
      S_MEM_ADDR: begin
        alu_src_a_w = 1'b1;
        alu_src_b_w = 2'b10;
      end
      S_MEM_READ: begin
        mem_read_w = 1'b1;
        i_or_d_w   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_w  = 1'b1;
        mem_to_reg_w = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_w = 1'b1;
        i_or_d_w    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_w   = 1'b1;
        alu_control_w = alu_r;
      end
      S_R_WB: begin
        reg_write_w = funct_ok;
        reg_dst_w   = 1'b1;
        illegal_w   = ~funct_ok;
      end
      S_BRANCH: begin
        alu_src_a_w   = 1'b1;
        alu_control_w = ALU_SUB;
        pc_source_w   = 2'b01;
        pc_write_w    = bus.zero;
      end
      S_JUMP: begin
        pc_source_w = 2'b10;
        pc_write_w  = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a_w   = 1'b1;
        alu_src_b_w   = 2'b10;
        alu_control_w = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB: reg_write_w = 1'b1;
      default: ;
    endcase
    // Reset must silence every strobe immediately, not just after the state register clears.
    if (rst) begin
      pc_write_w    = 1'b0;
      i_or_d_w      = 1'b0;
      mem_read_w    = 1'b0;
      mem_write_w   = 1'b0;
      ir_write_w    = 1'b0;
      reg_write_w   = 1'b0;
      reg_dst_w     = 1'b0;
      mem_to_reg_w  = 1'b0;
      alu_src_a_w   = 1'b0;
      alu_src_b_w   = 2'b00;
      pc_source_w   = 2'b00;
      alu_control_w = ALU_ADD;
      illegal_w     = 1'b0;
    end
  end

  assign bus.pc_write    = pc_write_w;
  assign bus.i_or_d      = i_or_d_w;
  assign bus.mem_read    = mem_read_w;
  assign bus.mem_write   = mem_write_w;
  assign bus.ir_write    = ir_write_w;
  assign bus.reg_write   = reg_write_w;
  assign bus.reg_dst     = reg_dst_w;
  assign bus.mem_to_reg  = mem_to_reg_w;
  assign bus.alu_src_a   = alu_src_a_w;
  assign bus.alu_src_b   = alu_src_b_w;
  assign bus.pc_source   = pc_source_w;
  assign bus.alu_control = alu_control_w;
  assign bus.illegal_op  = illegal_w;
  assign bus.state       = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle sequences checked every cycle.
module tb_multicycle_control;

`ifdef MC_IMM_ALU_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_control;
    logic       illegal_op;
  } out_t;

  typedef struct {
    int got;
    int exp;
    int id;
  } pin_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         len;
  } instr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  out_t dut_vec;
  assign dut_vec = {bus.state, bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write,
                    bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                    bus.alu_src_b, bus.pc_source, bus.alu_control, bus.illegal_op};

  int   n_cmp = 0;
  int   n_err = 0;
  out_t exp_cur;
  logic exp_valid = 1'b0;
  pin_t pin_q[$];
  out_t steps[$];

  // Single compare process: drains model pins, then checks the live outputs.
  always @(negedge clk) begin
    while (pin_q.size() > 0) begin
      pin_t p;
      p = pin_q.pop_front();
      n_cmp++;
      if (p.got != p.exp) begin
        n_err++;
        $display("FAIL model_pin%0d: got %0d required %0d", p.id, p.got, p.exp);
      end
    end
    if (exp_valid) begin
      n_cmp++;
      if (dut_vec !== exp_cur) begin
        n_err++;
        $display("FAIL outputs op=%b fn=%b: got st=%0d vec=%h required st=%0d vec=%h",
                 bus.opcode, bus.funct, dut_vec.state, dut_vec, exp_cur.state, exp_cur);
      end
    end
  end

  function automatic out_t mk(input logic [3:0] st);
    out_t o;
    o = '0;
    o.state = st;
    o.alu_control = 4'b0010;
    return o;
  endfunction

  function automatic out_t rst_vec();
    return mk(4'd0);
  endfunction

  // Expected cycle-by-cycle outputs of one instruction, from the instruction-class rules.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    out_t o;
    logic       fn_ok;
    logic [3:0] fn_alu;
    bit is_r, is_lw, is_sw, is_beq, is_j, is_imm;
    steps.delete();
    is_r   = (op == 6'b000000);
    is_lw  = (op == 6'b100011);
    is_sw  = (op == 6'b101011);
    is_beq = (op == 6'b000100);
    is_j   = (op == 6'b000010);
    is_imm = IMM_EN && (op == 6'b001000 || op == 6'b001010);
    fn_ok = 1'b1;
    case (fn)
      6'b100000: fn_alu = 4'b0010;
      6'b100010: fn_alu = 4'b0110;
      6'b100100: fn_alu = 4'b0000;
      6'b100101: fn_alu = 4'b0001;
      6'b101010: fn_alu = 4'b0111;
      6'b100111: fn_alu = 4'b1100;
      default: begin fn_alu = 4'b0010; fn_ok = 1'b0; end
    endcase
    o = mk(4'd0);
    o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1; o.alu_src_b = 2'b01;
    steps.push_back(o);
    o = mk(4'd1);
    o.alu_src_b = 2'b11;
    o.illegal_op = !(is_r || is_lw || is_sw || is_beq || is_j || is_imm);
    steps.push_back(o);
    if (is_lw || is_sw) begin
      o = mk(4'd2); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; steps.push_back(o);
    end
    if (is_lw) begin
      o = mk(4'd3); o.mem_read = 1'b1; o.i_or_d = 1'b1; steps.push_back(o);
      o = mk(4'd4); o.reg_write = 1'b1; o.mem_to_reg = 1'b1; steps.push_back(o);
    end
    if (is_sw) begin
      o = mk(4'd5); o.mem_write = 1'b1; o.i_or_d = 1'b1; steps.push_back(o);
    end
    if (is_r) begin
      o = mk(4'd6); o.alu_src_a = 1'b1; o.alu_control = fn_alu; steps.push_back(o);
      o = mk(4'd7); o.reg_write = fn_ok; o.reg_dst = 1'b1; o.illegal_op = !fn_ok;
      steps.push_back(o);
    end
    if (is_beq) begin
      o = mk(4'd8); o.alu_src_a = 1'b1; o.alu_control = 4'b0110; o.pc_source = 2'b01;
      o.pc_write = z; steps.push_back(o);
    end
    if (is_j) begin
      o = mk(4'd9); o.pc_source = 2'b10; o.pc_write = 1'b1; steps.push_back(o);
    end
    if (is_imm) begin
      o = mk(4'd10); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
      o.alu_control = (op == 6'b001010) ? 4'b0111 : 4'b0010; steps.push_back(o);
      o = mk(4'd11); o.reg_write = 1'b1; steps.push_back(o);
    end
  endtask

  // Called just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input instr_t t, input int id);
    bus.opcode = t.op;
    bus.funct  = t.fn;
    bus.zero   = t.z;
    build(t.op, t.fn, t.z);
    pin_q.push_back('{steps.size(), t.len, id});
    for (int i = 0; i < steps.size(); i++) begin
      exp_cur   = steps[i];
      exp_valid = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  instr_t prog[$];

  initial begin
    rst        = 1'b1;
    bus.opcode = 6'b000000;
    bus.funct  = 6'b000000;
    bus.zero   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_cur   = rst_vec();
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    prog.push_back('{6'b000000, 6'b100111, 1'b0, 4});
    prog.push_back('{6'b000000, 6'b100000, 1'b1, 4});
    prog.push_back('{6'b000000, 6'b100010, 1'b0, 4});
    prog.push_back('{6'b000000, 6'b100100, 1'b1, 4});
    prog.push_back('{6'b000000, 6'b100101, 1'b0, 4});
    prog.push_back('{6'b000000, 6'b101010, 1'b0, 4});
    prog.push_back('{6'b000000, 6'b000000, 1'b1, 4});
    prog.push_back('{6'b100011, 6'b000000, 1'b1, 5});
    prog.push_back('{6'b101011, 6'b000000, 1'b0, 4});
    prog.push_back('{6'b000100, 6'b000000, 1'b1, 3});
    prog.push_back('{6'b000100, 6'b000000, 1'b0, 3});
    prog.push_back('{6'b000010, 6'b000000, 1'b0, 3});
    prog.push_back('{6'b111111, 6'b000000, 1'b1, 2});
    prog.push_back('{6'b001000, 6'b000000, 1'b0, IMM_EN ? 4 : 2});
    prog.push_back('{6'b001010, 6'b000000, 1'b0, IMM_EN ? 4 : 2});
    prog.push_back('{6'b001100, 6'b000000, 1'b0, 2});

    // Hand-computed pins on the model's own tables.
    build(6'b000000, 6'b100111, 1'b0);
    pin_q.push_back('{int'(steps[2].alu_control), 12, 100});
    build(6'b100011, 6'b000000, 1'b0);
    pin_q.push_back('{int'(steps[4].mem_to_reg), 1, 101});
    build(6'b101011, 6'b000000, 1'b0);
    pin_q.push_back('{int'({steps[3].mem_write, steps[3].i_or_d}), 3, 102});
    build(6'b000100, 6'b000000, 1'b1);
    pin_q.push_back('{int'({steps[2].pc_write, steps[2].pc_source}), 5, 103});

    foreach (prog[k]) run_instr(prog[k], k);

    // Reset arrives mid-MEM_READ of a lw, between clock edges.
    bus.opcode = 6'b100011;
    bus.funct  = 6'b000000;
    build(6'b100011, 6'b000000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_cur   = steps[i];
      exp_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
    #1;
    rst       = 1'b1;
    exp_cur   = rst_vec();
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr('{6'b000010, 6'b000000, 1'b0, 3}, 200);
    run_instr('{6'b000000, 6'b100111, 1'b0, 4}, 201);

    exp_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

- Main control FSM for the multi-cycle variant of the CPU.
- Decodes the latched instruction's opcode/funct and drives the datapath enables and mux selects.
- Issues the 4-bit operation code to the ALU and consumes the ALU's `zero` flag for branch resolution.
- Sits between the instruction register and the shared ALU / memory / register-file datapath; one instruction completes every 3–5 cycles.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- opcode  in  6  instruction[31:26] from the instruction register; stable after FETCH
- funct  in  6  instruction[5:0]; used only for R-type
- zero  in  1  ALU zero flag; combinational, same cycle as alu_control
- pc_write  out  1  PC load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  ALU In1: 0 = PC, 1 = A
- alu_src_b  out  2  ALU In2: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- pc_source  out  2  PC next: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_control  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- illegal_op  out  1  one-cycle pulse on unsupported opcode/funct
- state  out  4  current state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
- Unlisted outputs are 0 in every state; alu_control defaults to ADD (0010).
- FETCH: mem_read, ir_write, pc_write, alu_src_b=01, ADD → DECODE.
- DECODE: alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 (lw), 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - anything else → FETCH, with illegal_op=1
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD → MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read, i_or_d=1 → MEM_WB.
- MEM_WB: reg_write, mem_to_reg=1 → FETCH.
- MEM_WRITE: mem_write, i_or_d=1 → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct → R_WB.
  - Funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR.
  - Any other funct drives ADD.
- R_WB: reg_write, reg_dst=1 → FETCH. Unsupported funct: reg_write=0 and illegal_op=1 (the instruction becomes a NOP).
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_write=zero → FETCH.
- JUMP: pc_source=10, pc_write=1 → FETCH.

## Timing
- Only the state register is clocked. Outputs are decoded combinationally from state plus opcode/funct/zero. pc_write in BRANCH depends combinationally on zero.
- Cycles per instruction, FETCH inclusive: R-type 4, lw 5, sw 4, beq 3, j 3, immediate ALU ops 4, illegal 2.
- Reset:
  - rst asserted → state=FETCH immediately, without waiting for clk.
  - While rst is high, every output is forced to 0, except alu_control=0010 and state=0.
- rst deasserted → first rising edge executes FETCH.
- Reset mid-instruction abandons the instruction with no register or memory write.
- opcode/funct changes outside FETCH are not supported; the IR is stable by construction.

## Configuration
- Macro `MC_IMM_ALU_EN`.
- Defined:
  - DECODE sends 001000 (addi) and 001010 (slti) to I_EXEC.
  - I_EXEC: alu_src_a=1, alu_src_b=10, ADD for addi, SLT for slti → I_WB.
  - I_WB: reg_write, reg_dst=0, mem_to_reg=0 → FETCH.
- Undefined: I_EXEC and I_WB are unreachable; both opcodes are illegal (DECODE → FETCH, illegal_op pulse).

## Test plan
- Reset: rst=1 mid-MEM_READ → state=0 and all strobes 0 before the next clk edge. Release rst → FETCH asserts mem_read, ir_write, pc_write with alu_control=0010.
- R-type: opcode=000000, funct=100111 → states 0,1,6,7. alu_control=1100 in R_EXEC. R_WB has reg_write=1, reg_dst=1.
- lw/sw: opcode=100011 → states 0,1,2,3,4, with mem_to_reg=1 in state 4. opcode=101011 → states 0,1,2,5, with mem_write=1 and i_or_d=1 in state 5.
- beq: zero=1 → pc_write=1, pc_source=01, alu_control=0110 in BRANCH. zero=0 → pc_write=0. Both return to FETCH after 3 cycles.
- Illegal: opcode=111111 → illegal_op pulses in DECODE, then FETCH. funct=000000 with opcode=0 → R_WB has reg_write=0 and illegal_op=1.
- Macro: opcode=001010 → with `MC_IMM_ALU_EN`, states 0,1,10,11 with alu_control=0111 in state 10. Without it, illegal_op pulses in DECODE.
